// File: rtl/p3_execute_pkg.sv
// Shared types for the p3 execute stage: opcodes, flag bit positions, FSM states.
package p3_execute_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_CMP  = 4'd5,
      OP_MOV  = 4'd6,
      OP_RSVD = 4'd7,
      OP_SLL  = 4'd8,
      OP_SLR  = 4'd9,
      OP_SRL  = 4'd10,
      OP_SRA  = 4'd11,
      OP_LD   = 4'd12,
      OP_ST   = 4'd13,
      OP_NOP  = 4'd14,
      OP_HLT  = 4'd15
   } op_e;

   // flags word is {S,Z,C,V}
   localparam int FLAG_V = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_S = 3;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

endpackage

// File: rtl/p3_alu.sv
// Combinational ALU for the p3 execute stage: result plus next {S,Z,C,V}.
// Non-ALU opcodes pass the incoming flags through untouched.
module p3_alu
   import p3_execute_pkg::*;
#(
   parameter int DATA_W = 16
)
(
   input  logic [3:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [3:0]        shamt_i,
   input  logic [3:0]        flags_i,
   output logic [DATA_W-1:0] result_o,
   output logic [3:0]        flags_o
);

   op_e               op_s;
   logic [DATA_W:0]   sum_s;
   logic [DATA_W:0]   diff_s;
   logic [DATA_W:0]   sll_s;
   logic [DATA_W:0]   srl_s;
   logic [DATA_W-1:0] rol_s;
   logic [DATA_W-1:0] sra_s;
   logic [DATA_W-1:0] res_s;
   logic              carry_s;
   logic              ovf_s;
   logic              upd_s;

   assign op_s   = op_e'(op_i);
   assign sum_s  = {1'b0, b_i} + {1'b0, a_i};
   // diff_s[DATA_W] is the borrow of B-A
   assign diff_s = {1'b0, b_i} - {1'b0, a_i};
   // extra bit on the exit side of each shift captures the last bit shifted out
   assign sll_s  = {1'b0, b_i} << shamt_i;
   assign srl_s  = {b_i, 1'b0} >> shamt_i;
   assign rol_s  = (b_i << shamt_i) | (b_i >> (DATA_W - int'(shamt_i)));
   assign sra_s  = $signed(b_i) >>> shamt_i;

   always_comb begin
      res_s   = {DATA_W{1'b0}};
      carry_s = 1'b0;
      ovf_s   = 1'b0;
      upd_s   = 1'b1;
      case (op_s)
         OP_ADD: begin
            res_s   = sum_s[DATA_W-1:0];
            carry_s = sum_s[DATA_W];
            ovf_s   = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum_s[DATA_W-1] != b_i[DATA_W-1]);
         end
         OP_SUB, OP_CMP: begin
            res_s   = diff_s[DATA_W-1:0];
            carry_s = diff_s[DATA_W];
            ovf_s   = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff_s[DATA_W-1] != b_i[DATA_W-1]);
         end
         OP_AND:  res_s = b_i & a_i;
         OP_OR:   res_s = b_i | a_i;
         OP_XOR:  res_s = b_i ^ a_i;
         OP_MOV:  res_s = a_i;
         OP_SLL: begin
            res_s   = sll_s[DATA_W-1:0];
            carry_s = sll_s[DATA_W];
         end
         OP_SLR: begin
            res_s   = rol_s;
            carry_s = sll_s[DATA_W];
         end
         OP_SRL: begin
            res_s   = srl_s[DATA_W:1];
            carry_s = srl_s[0];
         end
         OP_SRA:  res_s = sra_s;
         default: upd_s = 1'b0;
      endcase
   end

   always_comb begin
      flags_o = flags_i;
      if (upd_s) begin
         flags_o[FLAG_S] = res_s[DATA_W-1];
         flags_o[FLAG_Z] = (res_s == {DATA_W{1'b0}});
         flags_o[FLAG_C] = carry_s;
         flags_o[FLAG_V] = ovf_s;
      end else begin
         flags_o = flags_i;
      end
   end

   assign result_o = res_s;

endmodule

// File: rtl/p3_execute.sv
// p3 execute stage: pipeline registers, flags, RUN/HALT FSM and optional forwarding.
// Optional feature: define P3_FORWARD_EN to forward the previous ALU result into srcA/srcB.
module p3_execute
   import p3_execute_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              inValid,
   input  logic [3:0]        aluOp,
   input  logic [DATA_W-1:0] srcA,
   input  logic [DATA_W-1:0] srcB,
   input  logic [REG_AW-1:0] srcAReg,
   input  logic [REG_AW-1:0] srcBReg,
   input  logic [DATA_W-1:0] imm,
   input  logic [REG_AW-1:0] dstReg,
   output logic [DATA_W-1:0] address,
   output logic [DATA_W-1:0] storeData,
   output logic [DATA_W-1:0] aluOutput,
   output logic [REG_AW-1:0] regAddress,
   output logic              writeReg,
   output logic              writeEnable,
   output logic              readEnable,
   output logic [3:0]        flags,
   output logic              halted
);

   state_e            state_q, state_d;
   op_e               op_s;
   logic              accept_s;
   logic [DATA_W-1:0] a_s, b_s;
   logic [DATA_W-1:0] alu_res_s;
   logic [3:0]        alu_flags_s;
   logic [DATA_W-1:0] addr_sum_s;

   logic [DATA_W-1:0] address_q, address_d;
   logic [DATA_W-1:0] store_q, store_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [REG_AW-1:0] reg_q, reg_d;
   logic              wr_q, wr_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic [3:0]        flags_q, flags_d;
   logic              halted_s;

   assign op_s     = op_e'(aluOp);
   assign accept_s = inValid && (state_q == ST_RUN);

`ifdef P3_FORWARD_EN
   logic fwd_ok_s;
   // a load's aluOutput is not the loaded data, so loads never forward
   assign fwd_ok_s = wr_q && !re_q;
   assign a_s = (fwd_ok_s && (reg_q == srcAReg)) ? alu_q : srcA;
   assign b_s = (fwd_ok_s && (reg_q == srcBReg)) ? alu_q : srcB;
`else
   logic unused_src_regs_s;
   assign unused_src_regs_s = ^{srcAReg, srcBReg};
   assign a_s = srcA;
   assign b_s = srcB;
`endif

   assign addr_sum_s = b_s + imm;

   p3_alu #(.DATA_W(DATA_W)) u_alu (
      .op_i    (aluOp),
      .a_i     (a_s),
      .b_i     (b_s),
      .shamt_i (imm[3:0]),
      .flags_i (flags_q),
      .result_o(alu_res_s),
      .flags_o (alu_flags_s)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (inValid && (op_s == OP_HLT)) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      if (state_q == ST_HALT) begin
         halted_s = 1'b1;
      end else begin
         halted_s = 1'b0;
      end
   end

   // HLT, NOP and bubbles fall through with all strobes low and state held
   always_comb begin
      address_d = address_q;
      store_d   = store_q;
      alu_d     = alu_q;
      reg_d     = reg_q;
      flags_d   = flags_q;
      wr_d      = 1'b0;
      we_d      = 1'b0;
      re_d      = 1'b0;
      if (accept_s) begin
         reg_d = dstReg;
         case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV,
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
               alu_d   = alu_res_s;
               flags_d = alu_flags_s;
               wr_d    = 1'b1;
            end
            OP_CMP: begin
               alu_d   = alu_res_s;
               flags_d = alu_flags_s;
            end
            OP_LD: begin
               address_d = addr_sum_s;
               store_d   = a_s;
               re_d      = 1'b1;
               wr_d      = 1'b1;
            end
            OP_ST: begin
               address_d = addr_sum_s;
               store_d   = a_s;
               we_d      = 1'b1;
            end
            default: begin
               wr_d = 1'b0;
            end
         endcase
      end else begin
         reg_d = reg_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         address_q <= {DATA_W{1'b0}};
         store_q   <= {DATA_W{1'b0}};
         alu_q     <= {DATA_W{1'b0}};
         reg_q     <= {REG_AW{1'b0}};
         wr_q      <= 1'b0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         flags_q   <= 4'b0000;
      end else begin
         address_q <= address_d;
         store_q   <= store_d;
         alu_q     <= alu_d;
         reg_q     <= reg_d;
         wr_q      <= wr_d;
         we_q      <= we_d;
         re_q      <= re_d;
         flags_q   <= flags_d;
      end
   end

   assign address     = address_q;
   assign storeData   = store_q;
   assign aluOutput   = alu_q;
   assign regAddress  = reg_q;
   assign writeReg    = wr_q;
   assign writeEnable = we_q;
   assign readEnable  = re_q;
   assign flags       = flags_q;
   assign halted      = halted_s;

endmodule

// File: tb/tb_p3_execute.sv
// Bench for p3_execute: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_p3_execute;

   localparam int W  = 16;
   localparam int AW = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic          inValid;
   logic [3:0]    aluOp;
   logic [W-1:0]  srcA, srcB, imm;
   logic [AW-1:0] srcAReg, srcBReg, dstReg;
   logic [W-1:0]  address, storeData, aluOutput;
   logic [AW-1:0] regAddress;
   logic          writeReg, writeEnable, readEnable, halted;
   logic [3:0]    flags;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   p3_execute #(.DATA_W(W), .REG_AW(AW)) dut (
      .clock(clock), .reset(reset), .inValid(inValid), .aluOp(aluOp),
      .srcA(srcA), .srcB(srcB), .srcAReg(srcAReg), .srcBReg(srcBReg),
      .imm(imm), .dstReg(dstReg), .address(address), .storeData(storeData),
      .aluOutput(aluOutput), .regAddress(regAddress), .writeReg(writeReg),
      .writeEnable(writeEnable), .readEnable(readEnable), .flags(flags),
      .halted(halted)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a, b, im,
                        input logic [AW-1:0] dst, ar, br);
      inValid = v; aluOp = op; srcA = a; srcB = b; imm = im;
      dstReg = dst; srcAReg = ar; srcBReg = br;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // ---------------- reference model (spec rules in plain integer arithmetic) ----
   int         m_alu, m_addr, m_sd;
   logic [3:0] m_flags;
   logic       m_wr, m_we, m_re, m_halt;
   int         m_reg;

   task automatic model_reset();
      m_alu = 0; m_addr = 0; m_sd = 0; m_flags = 4'b0000;
      m_wr = 1'b0; m_we = 1'b0; m_re = 1'b0; m_halt = 1'b0; m_reg = 0;
   endtask

   function automatic int to_signed(input int x);
      return (x >= 32768) ? x - 65536 : x;
   endfunction

   task automatic model_step(input logic v, input int op, input int a_in, input int b_in,
                             input int im, input int ar, input int br, input int dst);
      int   a, b, res, s, n;
      logic c, ov;
      a = a_in; b = b_in;
`ifdef P3_FORWARD_EN
      if (m_wr && !m_re && m_reg == ar) a = m_alu;
      if (m_wr && !m_re && m_reg == br) b = m_alu;
`endif
      m_wr = 1'b0; m_we = 1'b0; m_re = 1'b0;
      if (!v || m_halt) return;
      if (op == 15) begin m_halt = 1'b1; return; end
      m_reg = dst;
      if (op == 12 || op == 13) begin
         m_addr = (b + im) % 65536;
         m_sd   = a;
         if (op == 12) begin m_re = 1'b1; m_wr = 1'b1; end
         else m_we = 1'b1;
         return;
      end
      if (op == 7 || op == 14) return;
      c = 1'b0; ov = 1'b0; res = 0;
      n = im % 16;
      case (op)
         0: begin
            res = a + b; c = (res > 65535); res = res % 65536;
            s = to_signed(a) + to_signed(b); ov = (s > 32767 || s < -32768);
         end
         1, 5: begin
            res = (b - a + 65536) % 65536; c = (b < a);
            s = to_signed(b) - to_signed(a); ov = (s > 32767 || s < -32768);
         end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         6: res = a;
         8: begin res = b; repeat (n) begin c = (res >= 32768); res = (res * 2) % 65536; end end
         9: begin res = b; repeat (n) begin c = (res >= 32768); res = (res * 2) % 65536 + (c ? 1 : 0); end end
         10: begin res = b; repeat (n) begin c = (res % 2 == 1); res = res / 2; end end
         11: begin res = b; repeat (n) res = res / 2 + ((res >= 32768) ? 32768 : 0); end
         default: res = 0;
      endcase
      m_flags = {(res >= 32768), (res == 0), c, ov};
      if (op != 5) begin m_alu = res; m_wr = 1'b1; end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       v;
      logic [3:0] op;
      logic [15:0] a, b, im;
      logic       chk_alu;
      logic [15:0] alu;
      logic [3:0] fl;
      logic       wr, we, re;
      logic [15:0] addr, sd;
   } vec_t;

   vec_t vt[19];

   initial begin
      logic [63:0] act, exp;
      logic [15:0] exp16;

      vt[0]  = '{1'b1, 4'd0,  16'h0001, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 4'h9, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
      vt[1]  = '{1'b1, 4'd5,  16'h0005, 16'h0005, 16'h0000, 1'b0, 16'h0000, 4'h4, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
      vt[2]  = '{1'b1, 4'd12, 16'hABCD, 16'hFFFF, 16'h0002, 1'b0, 16'h0000, 4'h4, 1'b1, 1'b0, 1'b1, 16'h0001, 16'hABCD};
      vt[3]  = '{1'b1, 4'd1,  16'h0001, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 4'hA, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hABCD};
      vt[4]  = '{1'b1, 4'd8,  16'h0000, 16'h8001, 16'h0001, 1'b1, 16'h0002, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hABCD};
      vt[5]  = '{1'b1, 4'd10, 16'h0000, 16'h0003, 16'h0001, 1'b1, 16'h0001, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hABCD};
      vt[6]  = '{1'b1, 4'd9,  16'h0000, 16'h9001, 16'h0004, 1'b1, 16'h0019, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hABCD};
      vt[7]  = '{1'b1, 4'd11, 16'h0000, 16'h8000, 16'h00FF, 1'b1, 16'hFFFF, 4'h8, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hABCD};
      vt[8]  = '{1'b1, 4'd8,  16'h0000, 16'h1234, 16'h0010, 1'b1, 16'h1234, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hABCD};
      vt[9]  = '{1'b1, 4'd4,  16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hABCD};
      vt[10] = '{1'b1, 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 16'h0000, 4'h6, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hABCD};
      vt[11] = '{1'b1, 4'd1,  16'h8000, 16'h0000, 16'h0000, 1'b1, 16'h8000, 4'hB, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hABCD};
      vt[12] = '{1'b1, 4'd13, 16'h5A5A, 16'h1000, 16'h0010, 1'b0, 16'h0000, 4'hB, 1'b0, 1'b1, 1'b0, 16'h1010, 16'h5A5A};
      vt[13] = '{1'b1, 4'd7,  16'h1111, 16'h2222, 16'h0000, 1'b0, 16'h0000, 4'hB, 1'b0, 1'b0, 1'b0, 16'h1010, 16'h5A5A};
      vt[14] = '{1'b0, 4'd0,  16'h0001, 16'h0001, 16'h0000, 1'b0, 16'h0000, 4'hB, 1'b0, 1'b0, 1'b0, 16'h1010, 16'h5A5A};
      vt[15] = '{1'b1, 4'd6,  16'h00F0, 16'h1234, 16'h0000, 1'b1, 16'h00F0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h1010, 16'h5A5A};
      vt[16] = '{1'b1, 4'd2,  16'h0F0F, 16'h00FF, 16'h0000, 1'b1, 16'h000F, 4'h0, 1'b1, 1'b0, 1'b0, 16'h1010, 16'h5A5A};
      vt[17] = '{1'b1, 4'd3,  16'h8000, 16'h0001, 16'h0000, 1'b1, 16'h8001, 4'h8, 1'b1, 1'b0, 1'b0, 16'h1010, 16'h5A5A};
      vt[18] = '{1'b1, 4'd14, 16'h3333, 16'h4444, 16'h0000, 1'b0, 16'h0000, 4'h8, 1'b0, 1'b0, 1'b0, 16'h1010, 16'h5A5A};

      reset = 1'b1;
      drive(1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd0);
      #2;
      check("reset_state",
            {address, storeData, aluOutput, regAddress, writeReg, writeEnable, readEnable, flags, halted},
            64'h0);
      #6 reset = 1'b0;

      // srcAReg/srcBReg = 7 never matches any dst (0..3), so forwarding stays out of the table
      for (int i = 0; i < 19; i++) begin
         drive(vt[i].v, vt[i].op, vt[i].a, vt[i].b, vt[i].im, 3'(i % 4), 3'd7, 3'd7);
         tick();
         act = {(vt[i].chk_alu ? aluOutput : 16'h0), flags, writeReg, writeEnable, readEnable,
                address, storeData, (vt[i].wr ? regAddress : 3'd0), halted};
         exp = {(vt[i].chk_alu ? vt[i].alu : 16'h0), vt[i].fl, vt[i].wr, vt[i].we, vt[i].re,
                vt[i].addr, vt[i].sd, (vt[i].wr ? 3'(i % 4) : 3'd0), 1'b0};
         check($sformatf("vec%0d", i), act, exp);
      end

      // ---- HLT then ADD, then asynchronous reset back to RUN ----
      reset = 1'b1; #2 reset = 1'b0;
      drive(1'b1, 4'd0, 16'h0001, 16'h7FFF, 16'h0000, 3'd1, 3'd7, 3'd7);
      tick();
      check("hlt_pre_flags", {aluOutput, flags}, {16'h8000, 4'h9});
      drive(1'b1, 4'd15, 16'h0000, 16'h0000, 16'h0000, 3'd2, 3'd7, 3'd7);
      tick();
      check("hlt_retire", {halted, writeReg, writeEnable, readEnable, flags}, {1'b1, 1'b0, 1'b0, 1'b0, 4'h9});
      drive(1'b1, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'd3, 3'd7, 3'd7);
      tick();
      check("halt_add_ignored", {halted, writeReg, flags, aluOutput}, {1'b1, 1'b0, 4'h9, 16'h8000});
      #2 reset = 1'b1;
      #1 check("halt_async_reset", {halted, flags, aluOutput, writeReg}, 64'h0);
      #1 reset = 1'b0;
      drive(1'b1, 4'd0, 16'h0001, 16'h0001, 16'h0000, 3'd4, 3'd7, 3'd7);
      tick();
      check("run_after_reset", {halted, writeReg, aluOutput, regAddress}, {1'b0, 1'b1, 16'h0002, 3'd4});

      // ---- reset between edges while a store is on the outputs ----
      drive(1'b1, 4'd13, 16'h0001, 16'h0002, 16'h0003, 3'd0, 3'd7, 3'd7);
      tick();
      check("st_before_reset", {writeEnable, address, storeData}, {1'b1, 16'h0005, 16'h0001});
      #2 reset = 1'b1;
      #1 check("st_async_reset", {writeEnable, readEnable, address, storeData}, 64'h0);
      #1 reset = 1'b0;

      // ---- forwarding: ALU result forwarded, load result not ----
      drive(1'b1, 4'd6, 16'h1234, 16'h0000, 16'h0000, 3'd1, 3'd7, 3'd7);
      tick();
      drive(1'b1, 4'd0, 16'h0000, 16'h0001, 16'h0000, 3'd3, 3'd1, 3'd2);
      tick();
`ifdef P3_FORWARD_EN
      exp16 = 16'h1235;
`else
      exp16 = 16'h0001;
`endif
      check("fwd_alu_result", aluOutput, exp16);
      drive(1'b1, 4'd12, 16'h0000, 16'h0000, 16'h0000, 3'd1, 3'd7, 3'd7);
      tick();
      drive(1'b1, 4'd0, 16'h0002, 16'h0001, 16'h0000, 3'd3, 3'd1, 3'd2);
      tick();
      check("no_fwd_after_ld", aluOutput, 16'h0003);

      // ---- randomized traffic against the reference model ----
      reset = 1'b1; #2 reset = 1'b0;
      model_reset();
      for (int k = 0; k < 400; k++) begin
         int rv, rop, ra, rb, rim, rar, rbr, rdst;
         rv   = ($urandom_range(0, 9) != 0) ? 1 : 0;
         rop  = $urandom_range(0, 14);
         ra   = $urandom_range(0, 65535);
         rb   = $urandom_range(0, 65535);
         rim  = $urandom_range(0, 65535);
         rar  = $urandom_range(0, 7);
         rbr  = $urandom_range(0, 7);
         rdst = $urandom_range(0, 7);
         if ($urandom_range(0, 3) == 0) ra = (k % 2 == 0) ? 32768 : 65535;
         drive(1'(rv), 4'(rop), 16'(ra), 16'(rb), 16'(rim), 3'(rdst), 3'(rar), 3'(rbr));
         model_step(1'(rv), rop, ra, rb, rim, rar, rbr, rdst);
         tick();
         act = {halted, flags, writeReg, writeEnable, readEnable, address, storeData,
                ((m_wr && !m_re) ? aluOutput : 16'h0), (m_wr ? regAddress : 3'd0)};
         exp = {m_halt, m_flags, m_wr, m_we, m_re, 16'(m_addr), 16'(m_sd),
                ((m_wr && !m_re) ? 16'(m_alu) : 16'h0), (m_wr ? 3'(m_reg) : 3'd0)};
         check($sformatf("rand%0d_op%0d", k, rop), act, exp);
         if (writeEnable && readEnable) begin
            n_tests++;
            n_fail++;
            $display("FAIL rw_exclusive: got we=1 re=1 required not both");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/p3_execute.md
P3_EXECUTE -- requirements
Module: p3_execute

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width.
REQ-002 SHALL have parameter REG_AW, default 3, register-address width.
REQ-003 SHALL have the ports listed below; there is one clock, and reset is asynchronous and active-high.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- inValid  in  1  decode stage presents an instruction.
- aluOp  in  4  operation code.
- srcA  in  DATA_W  Rs operand.
- srcB  in  DATA_W  Rd/Rb operand.
- srcAReg, srcBReg  in  REG_AW  source register numbers.
- imm  in  DATA_W  displacement or shift amount (shift uses imm[3:0]).
- dstReg  in  REG_AW  destination register.
- address  out  DATA_W  memory address to p4.
- storeData  out  DATA_W  store data to p4.
- aluOutput  out  DATA_W  ALU result to p4.
- regAddress  out  REG_AW  destination register to p4.
- writeReg  out  1  result is written back.
- writeEnable  out  1  memory write.
- readEnable  out  1  memory read.
- flags  out  4  {S,Z,C,V}.
- halted  out  1  HLT retired.

Function
REQ-004 SHALL register all outputs: an instruction accepted at edge N appears on the outputs after edge N, a latency of 1 cycle.
REQ-005 SHALL use these opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 MOV, 8 SLL, 9 SLR (rotate left), 10 SRL, 11 SRA, 12 LD, 13 ST, 14 NOP, 15 HLT.
- Opcode 7 SHALL behave as NOP.
REQ-006 ALU results SHALL be defined as follows:
- ADD = B+A; SUB and CMP = B-A; AND, OR and XOR are bitwise on B,A; MOV = A.
- Shifts act on B by imm[3:0]; a shift amount of 0 yields B.
- All results are truncated to DATA_W.
REQ-007 Flags SHALL be updated as follows:
- ADD, SUB and CMP update all of S, Z, C, V: C is the carry-out (ADD) or borrow (SUB/CMP); V is two's-complement overflow.
- Logic ops, MOV and shifts update S and Z and clear C and V.
- SLL, SLR and SRL with a nonzero amount set C to the last bit shifted out.
- LD, ST, NOP and HLT leave the flags unchanged.
REQ-008 The control outputs SHALL be set per opcode:
- writeReg=1 for ADD, SUB, logic ops, MOV, shifts and LD.
- CMP, ST, NOP and HLT give writeReg=0.
REQ-009 For LD and ST: address = B+imm (wrap modulo 2^DATA_W) and storeData = A. LD gives readEnable=1; ST gives writeEnable=1. All other opcodes drive both low.
REQ-010 For non-memory ops, address and storeData SHALL hold their previous values.
REQ-011 When inValid=0, the block SHALL issue a bubble: writeReg, writeEnable and readEnable are 0, and flags are unchanged.
REQ-012 The FSM SHALL have two states, RUN and HALT:
- In RUN, an accepted HLT moves the FSM to HALT.
- In HALT, halted=1 and every input is treated as a bubble until reset.
- The HLT instruction itself retires as a bubble.
REQ-013 readEnable and writeEnable SHALL never both be 1 in the same cycle.

Reset
REQ-014 Asserting reset SHALL immediately, without a clock edge, force all outputs to 0 and the FSM to RUN. This applies mid-instruction, and the in-flight result is discarded.
REQ-015 After reset deasserts, the first edge with inValid=1 SHALL be accepted normally.

Configuration
REQ-016 With P3_FORWARD_EN defined:
- If the previous accepted instruction had writeReg=1, readEnable=0, and regAddress equal to srcAReg (or srcBReg), then the registered aluOutput SHALL replace srcA (or srcB).
- LD results SHALL never be forwarded; load-use spacing is the decoder's responsibility.
REQ-017 Without P3_FORWARD_EN, srcA and srcB SHALL be used unmodified, and srcAReg and srcBReg SHALL be ignored.

Structure
REQ-018 The shared package SHALL hold: the opcode enum, the flag-bit index constants, and the FSM state enum.
REQ-019 The combinational ALU (result plus next flags) SHALL be a sub-module named p3_alu. p3_execute holds the pipeline registers, flags, FSM and forwarding.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ADD A=0x0001, B=0x7FFF -> aluOutput=0x8000, flags S=1 Z=0 C=0 V=1, writeReg=1, one cycle later.
- CMP A=0x0005, B=0x0005 -> Z=1 C=0, writeReg=0, aluOutput register value irrelevant.
- LD B=0xFFFF, imm=0x0002 -> address=0x0001, readEnable=1, writeEnable=0.
- HLT then ADD -> halted=1, writeReg=0 and flags frozen for the ADD; reset returns the FSM to RUN.
- P3_FORWARD_EN: MOV R1<-0x1234, then ADD with srcAReg=1 and stale srcA=0 -> uses 0x1234. A LD to R1 followed by a read of R1 is not forwarded.
- Reset asserted between edges during ST -> writeEnable drops to 0 immediately.
